cdc_bus_arbiter: RTL



---
 rtl/cdc_bus_arbiter_pkg.sv | 22 ++
 rtl/cdc_bus_arbiter_if.sv | 30 +++
 rtl/cdc_bus_arbiter_rr_arb2.sv | 16 +
 rtl/cdc_bus_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/cdc_bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester bus-synchronizer arbiter.
// Phase encoding and the HOLD/GAP timing defaults live here.
package cdc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int DEF_BUS_WIDTH   = 8;
  localparam int DEF_HOLD_CYCLES = 6;
  localparam int DEF_GAP_CYCLES  = 6;
  localparam int DEF_CNT_WIDTH   = 4;

  // The phase counter must reach the larger terminal count without wrapping.
  function automatic bit cnt_fits(int cw, int hold, int gap);
    return (1 << cw) > ((hold > gap) ? hold : gap);
  endfunction

endpackage

// File: rtl/cdc_bus_arbiter_if.sv
// Requester handshakes plus synchronizer-facing bus of the arbiter.
// master = arbiter side, slave = requesters / synchronizer side.
interface cdc_bus_arbiter_if
  import cdc_bus_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH
) ();

  logic                 req0;
  logic [BUS_WIDTH-1:0] data0;
  logic                 ack0;
  logic                 req1;
  logic [BUS_WIDTH-1:0] data1;
  logic                 ack1;
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic                 busy;
  logic                 grant_id;

  modport master (
    input  req0, data0, req1, data1,
    output ack0, ack1, unsync_bus, bus_enable, busy, grant_id
  );

  modport slave (
    output req0, data0, req1, data1,
    input  ack0, ack1, unsync_bus, bus_enable, busy, grant_id
  );

endinterface

// File: rtl/cdc_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the requester that did not win last time.
module rr_arb2
  import cdc_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/cdc_bus_arbiter.sv
// Source-domain sequencer sharing one bus synchronizer between two requesters:
// capture word, setup cycle, enable-high hold window, enable-low guard window.
module cdc_bus_arbiter
  import cdc_bus_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  cdc_bus_arbiter_if.master  bus
);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
      !cnt_fits(CNT_WIDTH, HOLD_CYCLES, GAP_CYCLES)) begin : g_param_chk
    $error("cdc_bus_arbiter: bad HOLD/GAP/CNT_WIDTH combination");
  end

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);

  arb_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] word_q, word_d;
  logic                 en_q, en_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 gid_q, gid_d;
  logic                 last_q, last_d;

  logic                      any_req;
  logic                      winner;
  logic [1:0][BUS_WIDTH-1:0] req_data;

  assign req_data = {bus.data1, bus.data0};

  rr_arb2 u_arb (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      en_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      en_q    <= en_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
    end
  end

  // Outputs are computed one cycle ahead so every bus-facing signal is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    en_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    gid_d   = gid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SETUP;
          cnt_d   = '0;
          word_d  = req_data[winner];
          gid_d   = winner;
          last_d  = winner;
          ack0_d  = ~winner;
          ack1_d  = winner;
        end
      end
      SETUP: begin
        state_d = HOLD;
        cnt_d   = '0;
        en_d    = 1'b1;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          en_d  = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.unsync_bus = word_q;
  assign bus.bus_enable = en_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_id   = gid_q;

endmodule
